// File: rtl/call_stack_spill.sv
// ============================================================================
// Module      : call_stack_spill
// Description : Return-address stack with an on-chip circular window that
//               spills its oldest entries to data memory and refills on drain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module call_stack_spill #(
  parameter int          WINDOW      = 8,
  parameter int          SPILL_DEPTH = 64,
  parameter logic [15:0] SPILL_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        push,
  input  logic        pop,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic [7:0]  depth,
  output logic        overflow,
  output logic        underflow,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int c_PW = $clog2(WINDOW);
  localparam int c_CW = c_PW + 1;
  localparam int c_SW = $clog2(SPILL_DEPTH) + 1;
  localparam logic [c_CW-1:0] c_WIN = c_CW'(WINDOW);
  localparam logic [c_SW-1:0] c_SPD = c_SW'(SPILL_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SPILL = 2'd1,
    S_FILL  = 2'd2
  } state_t;

  state_t            r_state;
  logic [c_CW-1:0]   r_count;
  logic [c_SW-1:0]   r_sp;
  logic [c_PW-1:0]   r_bot;
  logic [15:0]       r_win [WINDOW];
  logic              r_ovf;
  logic              r_udf;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [15:0]       r_mem_addr;
  logic [15:0]       r_mem_wdata;

  logic              w_accept;
  logic              w_full;
  logic              w_empty;
  logic              w_sp_full;
  logic              w_sp_empty;
  logic [c_PW-1:0]   w_top_idx;
  logic [c_PW-1:0]   w_next_idx;
  logic [c_PW-1:0]   w_push_idx;
  logic              w_push_wr;
  logic              w_inc;
  logic              w_dec;
  logic              w_set_ovf;
  logic              w_set_udf;
  logic              w_fill_ack;

  always_comb begin
    w_accept   = en && (r_state == S_IDLE);
    w_full     = (r_count == c_WIN);
    w_empty    = (r_count == '0);
    w_sp_full  = (r_sp == c_SPD);
    w_sp_empty = (r_sp == '0);
    w_next_idx = r_bot + r_count[c_PW-1:0];
    w_top_idx  = w_next_idx - c_PW'(1);
    // A lone push into a full window is never stored: the spill is already
    // scheduled for the next edge and there is no free slot to hold it.
    w_push_wr  = w_accept && push && (pop || !w_full);
    w_push_idx = (pop && !w_empty) ? w_top_idx : w_next_idx;
    w_inc      = w_accept && push && ((pop && w_empty) || (!pop && !w_full));
    w_dec      = w_accept && pop && !push && !w_empty;
    w_set_ovf  = w_accept && push && !pop && w_full && w_sp_full;
    w_set_udf  = w_accept && pop && w_empty && (push || w_sp_empty);
    w_fill_ack = (r_state == S_FILL) && mem_ack;
  end

  always_ff @(posedge clk) begin
    if (w_fill_ack) begin
      r_win[r_bot - c_PW'(1)] <= mem_rdata;
    end else if (w_push_wr) begin
      r_win[w_push_idx] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_sp        <= '0;
      r_bot       <= '0;
      r_ovf       <= 1'b0;
      r_udf       <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      if (w_set_ovf) r_ovf <= 1'b1;
      if (w_set_udf) r_udf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_inc) begin
            r_count <= r_count + c_CW'(1);
          end else if (w_dec) begin
            r_count <= r_count - c_CW'(1);
          end
          if (w_full && !w_sp_full) begin
            r_state     <= S_SPILL;
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= SPILL_BASE + 16'(r_sp);
            r_mem_wdata <= r_win[r_bot];
          end else if (w_empty && !w_sp_empty) begin
            r_state    <= S_FILL;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= SPILL_BASE + 16'(r_sp) - 16'd1;
          end
        end
        S_SPILL: begin
          if (mem_ack) begin
            r_bot     <= r_bot + c_PW'(1);
            r_count   <= r_count - c_CW'(1);
            r_sp      <= r_sp + c_SW'(1);
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_bot     <= r_bot - c_PW'(1);
            r_count   <= r_count + c_CW'(1);
            r_sp      <= r_sp - c_SW'(1);
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign data_out  = w_empty ? 16'h0000 : r_win[w_top_idx];
  assign stall     = (r_state != S_IDLE);
  assign depth     = 8'(r_count) + 8'(r_sp);
  assign overflow  = r_ovf;
  assign underflow = r_udf;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_call_stack_spill.sv
// ============================================================================
// Module      : tb_call_stack_spill
// Description : Directed self-checking bench for call_stack_spill, covering a
//               default window and a tiny window/spill configuration.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_call_stack_spill;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  logic        a_en, a_push, a_pop, a_ack;
  logic [15:0] a_din, a_rdata;
  logic [15:0] a_dout, a_addr, a_wdata;
  logic [7:0]  a_depth;
  logic        a_stall, a_ovf, a_udf, a_req, a_we;

  logic        b_en, b_push, b_pop, b_ack;
  logic [15:0] b_din, b_rdata;
  logic [15:0] b_dout, b_addr, b_wdata;
  logic [7:0]  b_depth;
  logic        b_stall, b_ovf, b_udf, b_req, b_we;

  call_stack_spill #(.WINDOW(8), .SPILL_DEPTH(64), .SPILL_BASE(16'hFF00)) dut_a (
    .clk(clk), .rst(rst), .en(a_en), .push(a_push), .pop(a_pop),
    .data_in(a_din), .data_out(a_dout), .stall(a_stall), .depth(a_depth),
    .overflow(a_ovf), .underflow(a_udf), .mem_req(a_req), .mem_we(a_we),
    .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_rdata(a_rdata), .mem_ack(a_ack)
  );

  call_stack_spill #(.WINDOW(2), .SPILL_DEPTH(2), .SPILL_BASE(16'hFF00)) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .push(b_push), .pop(b_pop),
    .data_in(b_din), .data_out(b_dout), .stall(b_stall), .depth(b_depth),
    .overflow(b_ovf), .underflow(b_udf), .mem_req(b_req), .mem_we(b_we),
    .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_rdata(b_rdata), .mem_ack(b_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_en = 0; a_push = 0; a_pop = 0; a_ack = 0; a_din = '0; a_rdata = '0;
    b_en = 0; b_push = 0; b_pop = 0; b_ack = 0; b_din = '0; b_rdata = '0;
    tick();
    do_reset();

    // Reset state
    chk("rst_depth", 32'(a_depth), 32'd0);
    chk("rst_dout", 32'(a_dout), 32'd0);
    chk("rst_stall", 32'(a_stall), 32'd0);
    chk("rst_req", 32'(a_req), 32'd0);
    chk("rst_addr", 32'(a_addr), 32'd0);
    chk("rst_ovf", 32'(a_ovf), 32'd0);
    chk("rst_udf", 32'(a_udf), 32'd0);

    // Fill the window and spill the oldest entry
    a_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a_push = 1'b1;
      a_din  = 16'h1000 + 16'(i);
      tick();
    end
    a_push = 1'b0;
    chk("full_stall_pre", 32'(a_stall), 32'd0);
    chk("full_depth", 32'(a_depth), 32'd8);
    chk("full_dout", 32'(a_dout), 32'h1007);
    tick();
    chk("spill_stall", 32'(a_stall), 32'd1);
    chk("spill_req", 32'(a_req), 32'd1);
    chk("spill_we", 32'(a_we), 32'd1);
    chk("spill_addr", 32'(a_addr), 32'hFF00);
    chk("spill_wdata", 32'(a_wdata), 32'h1000);
    tick();
    tick();
    chk("spill_req_hold", 32'(a_req), 32'd1);
    chk("spill_addr_hold", 32'(a_addr), 32'hFF00);
    a_ack = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("spill_done_stall", 32'(a_stall), 32'd0);
    chk("spill_done_req", 32'(a_req), 32'd0);
    chk("spill_done_depth", 32'(a_depth), 32'd8);
    chk("spill_done_dout", 32'(a_dout), 32'h1007);

    // Drain the window, then refill from memory
    for (int k = 1; k <= 7; k++) begin
      a_pop = 1'b1;
      tick();
      chk("pop_dout", 32'(a_dout), (k < 7) ? (32'h1007 - 32'(k)) : 32'd0);
    end
    a_pop = 1'b0;
    chk("drain_depth", 32'(a_depth), 32'd1);
    chk("drain_stall", 32'(a_stall), 32'd0);
    tick();
    chk("fill_stall", 32'(a_stall), 32'd1);
    chk("fill_req", 32'(a_req), 32'd1);
    chk("fill_we", 32'(a_we), 32'd0);
    chk("fill_addr", 32'(a_addr), 32'hFF00);
    a_rdata = 16'h1000;
    a_ack   = 1'b1;
    tick();
    a_ack = 1'b0;
    chk("fill_dout", 32'(a_dout), 32'h1000);
    chk("fill_stall_done", 32'(a_stall), 32'd0);
    chk("fill_depth", 32'(a_depth), 32'd1);
    chk("fill_req_done", 32'(a_req), 32'd0);

    // Simultaneous push and pop overwrites the top
    do_reset();
    a_push = 1'b1; a_din = 16'hABCD;
    tick();
    a_pop = 1'b1; a_din = 16'h1234;
    tick();
    a_push = 1'b0; a_pop = 1'b0;
    chk("pp_dout", 32'(a_dout), 32'h1234);
    chk("pp_depth", 32'(a_depth), 32'd1);
    chk("pp_udf", 32'(a_udf), 32'd0);
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("pp_pop_depth", 32'(a_depth), 32'd0);
    chk("pp_pop_dout", 32'(a_dout), 32'd0);
    tick();
    chk("pp_no_fill", 32'(a_req), 32'd0);

    // Underflow on empty stack is sticky
    do_reset();
    a_pop = 1'b1;
    tick();
    a_pop = 1'b0;
    chk("udf_set", 32'(a_udf), 32'd1);
    chk("udf_depth", 32'(a_depth), 32'd0);
    chk("udf_req", 32'(a_req), 32'd0);
    tick();
    chk("udf_stall", 32'(a_stall), 32'd0);
    a_push = 1'b1; a_din = 16'h0042;
    tick();
    a_push = 1'b0;
    chk("udf_push_dout", 32'(a_dout), 32'h0042);
    chk("udf_sticky", 32'(a_udf), 32'd1);
    chk("udf_push_depth", 32'(a_depth), 32'd1);

    // Small configuration: spill area fills, fifth push is dropped
    do_reset();
    b_en = 1'b1;
    b_push = 1'b1; b_din = 16'hE000;
    tick();
    b_din = 16'hE001;
    tick();
    b_push = 1'b0;
    tick();
    chk("b_sp0_req", 32'(b_req), 32'd1);
    chk("b_sp0_addr", 32'(b_addr), 32'hFF00);
    chk("b_sp0_wdata", 32'(b_wdata), 32'hE000);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("b_sp0_depth", 32'(b_depth), 32'd2);
    b_push = 1'b1; b_din = 16'hE002;
    tick();
    b_push = 1'b0;
    tick();
    chk("b_sp1_req", 32'(b_req), 32'd1);
    chk("b_sp1_addr", 32'(b_addr), 32'hFF01);
    chk("b_sp1_wdata", 32'(b_wdata), 32'hE001);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("b_sp1_depth", 32'(b_depth), 32'd3);
    b_push = 1'b1; b_din = 16'hE003;
    tick();
    chk("b_full_depth", 32'(b_depth), 32'd4);
    chk("b_full_ovf", 32'(b_ovf), 32'd0);
    b_din = 16'hE004;
    tick();
    b_push = 1'b0;
    chk("b_ovf_set", 32'(b_ovf), 32'd1);
    chk("b_ovf_depth", 32'(b_depth), 32'd4);
    chk("b_ovf_dout", 32'(b_dout), 32'hE003);
    tick();
    chk("b_no_spill_req", 32'(b_req), 32'd0);
    chk("b_no_spill_stall", 32'(b_stall), 32'd0);

    // Asynchronous reset in the middle of a spill
    do_reset();
    for (int i = 0; i < 8; i++) begin
      a_push = 1'b1;
      a_din  = 16'h2000 + 16'(i);
      tick();
    end
    a_push = 1'b0;
    tick();
    chk("ar_stall_pre", 32'(a_stall), 32'd1);
    chk("ar_req_pre", 32'(a_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_req", 32'(a_req), 32'd0);
    chk("ar_stall", 32'(a_stall), 32'd0);
    chk("ar_depth", 32'(a_depth), 32'd0);
    chk("ar_dout", 32'(a_dout), 32'd0);
    tick();
    rst = 1'b0;
    a_push = 1'b1; a_din = 16'h5555;
    tick();
    a_push = 1'b0;
    chk("ar_push_dout", 32'(a_dout), 32'h5555);
    chk("ar_push_depth", 32'(a_depth), 32'd1);
    chk("ar_push_stall", 32'(a_stall), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
